// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multipliers: FSM encoding, index widths and
// the flat-packing offset rule (element 0 at the MSBs).
package matrix_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCompute = 2'd1,
        StDone    = 2'd2
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // LSB position of flat element n in a vector holding total elements of w bits.
    function automatic int unsigned elem_lsb(input int unsigned n,
                                             input int unsigned total,
                                             input int unsigned w);
        return (total - 1 - n) * w;
    endfunction

endpackage

// File: rtl/matrix_mac.sv
// Combinational multiply-add: sum = acc + a*b, all truncated to word_size bits.
module matrix_mac #(
    parameter int unsigned word_size = 32
) (
    input  logic [word_size-1:0] acc,
    input  logic [word_size-1:0] a,
    input  logic [word_size-1:0] b,
    output logic [word_size-1:0] sum
);

    logic [word_size-1:0] prod;

    always_comb begin
        prod = a * b;
        sum  = acc + prod;
    end

endmodule

// File: rtl/matrix_mul_seq.sv
// Resource-shared matrix multiplier: one MAC steps through i/j/k, handshakes on both sides.
module matrix_mul_seq
    import matrix_pkg::*;
#(
    parameter int unsigned word_size     = 32,
    parameter int unsigned Amatrixrownum = 2,
    parameter int unsigned Amatrixcolnum = 2,
    parameter int unsigned Bmatrixcolnum = 1
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [Amatrixrownum*Amatrixcolnum*word_size-1:0] A,
    input  logic [Amatrixcolnum*Bmatrixcolnum*word_size-1:0] B,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [Amatrixrownum*Bmatrixcolnum*word_size-1:0] MP,
    output logic                                            busy
);

    localparam int unsigned M  = Amatrixrownum;
    localparam int unsigned K  = Amatrixcolnum;
    localparam int unsigned N  = Bmatrixcolnum;
    localparam int unsigned IW = idx_width(M);
    localparam int unsigned JW = idx_width(N);
    localparam int unsigned KW = idx_width(K);
    localparam int unsigned AW = M * K * word_size;
    localparam int unsigned BW = K * N * word_size;
    localparam int unsigned PW = M * N * word_size;

    state_e               state_q, state_d;
    logic [AW-1:0]        a_q, a_d;
    logic [BW-1:0]        b_q, b_d;
    logic [PW-1:0]        mp_q, mp_d;
    logic [word_size-1:0] acc_q, acc_d;
    logic [IW-1:0]        i_q, i_d;
    logic [JW-1:0]        j_q, j_d;
    logic [KW-1:0]        k_q, k_d;

    logic [31:0]          a_idx, b_idx, mp_idx;
    logic [word_size-1:0] a_elem, b_elem, mac_sum;

    assign a_idx  = 32'(i_q) * K + 32'(k_q);
    assign b_idx  = 32'(k_q) * N + 32'(j_q);
    assign mp_idx = 32'(i_q) * N + 32'(j_q);

    always_comb begin
        a_elem = '0;
        b_elem = '0;
        for (int unsigned n = 0; n < M * K; n++) begin
            if (a_idx == n) a_elem = a_q[elem_lsb(n, M * K, word_size) +: word_size];
        end
        for (int unsigned n = 0; n < K * N; n++) begin
            if (b_idx == n) b_elem = b_q[elem_lsb(n, K * N, word_size) +: word_size];
        end
    end

    matrix_mac #(
        .word_size(word_size)
    ) u_mac (
        .acc(acc_q),
        .a  (a_elem),
        .b  (b_elem),
        .sum(mac_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            mp_q    <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mp_q    <= mp_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mp_d    = mp_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                if (k_q != KW'(K - 1)) begin
                    k_d   = k_q + 1'b1;
                    acc_d = mac_sum;
                end else begin
                    // Last inner step: the sum goes straight to MP, acc restarts at zero.
                    for (int unsigned n = 0; n < M * N; n++) begin
                        if (mp_idx == n) mp_d[elem_lsb(n, M * N, word_size) +: word_size] = mac_sum;
                    end
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q != JW'(N - 1)) begin
                        j_d = j_q + 1'b1;
                    end else begin
                        j_d = '0;
                        if (i_q != IW'(M - 1)) begin
                            i_d = i_q + 1'b1;
                        end else begin
                            i_d     = '0;
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign MP        = mp_q;

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Directed bench for matrix_mul_seq: default 2x2*2x1, an 8-bit wrap instance and a 3x1*1x3 instance.
module tb_matrix_mul_seq;

    logic clk;
    logic rst_n;

    logic         v0, rdy0, ov0, ordy0, busy0;
    logic [127:0] a0;
    logic [63:0]  b0, mp0;

    logic         v1, rdy1, ov1, ordy1, busy1;
    logic [31:0]  a1;
    logic [15:0]  b1, mp1;

    logic         v2, rdy2, ov2, ordy2, busy2;
    logic [95:0]  a2, b2;
    logic [287:0] mp2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] a;
        logic [63:0]  b;
        logic [63:0]  mp;
    } vec_t;

    vec_t vecs[4];

    matrix_mul_seq u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .A(a0), .B(b0),
        .out_valid(ov0), .out_ready(ordy0), .MP(mp0), .busy(busy0)
    );

    matrix_mul_seq #(
        .word_size(8), .Amatrixrownum(2), .Amatrixcolnum(2), .Bmatrixcolnum(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .A(a1), .B(b1),
        .out_valid(ov1), .out_ready(ordy1), .MP(mp1), .busy(busy1)
    );

    matrix_mul_seq #(
        .word_size(32), .Amatrixrownum(3), .Amatrixcolnum(1), .Bmatrixcolnum(3)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .A(a2), .B(b2),
        .out_valid(ov2), .out_ready(ordy2), .MP(mp2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic job0(input logic [127:0] a, input logic [63:0] b, input logic [63:0] exp,
                        input string tag);
        int n;
        n = 0;
        while (!rdy0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        a0 = a;
        b0 = b;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        a0 = '0;
        b0 = '0;
        n  = 1;
        while (!ov0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 512'(n), 512'(5));
        check({tag, "_mp"}, 512'(mp0), 512'(exp));
        ordy0 = 1'b1;
        @(negedge clk);
        ordy0 = 1'b0;
        check({tag, "_ready_after"}, 512'({rdy0, ov0}), 512'(2'b10));
    endtask

    initial begin
        int n;
        int n_in, n_out;
        int t_in[2];
        int t_out[2];
        logic [63:0] mp_out[2];

        vecs[0] = '{a: {32'd1, 32'd2, 32'd3, 32'd4}, b: {32'd5, 32'd6}, mp: {32'd17, 32'd39}};
        vecs[1] = '{a: {32'd10, 32'd20, 32'd30, 32'd40}, b: {32'd1, 32'd2},
                    mp: {32'd50, 32'd110}};
        vecs[2] = '{a: {32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3}, b: {32'd2, 32'd3},
                    mp: {32'd1, 32'd13}};
        vecs[3] = '{a: {32'd0, 32'd7, 32'd0, 32'd0}, b: {32'd9, 32'd11}, mp: {32'd77, 32'd0}};

        rst_n = 1'b0;
        {v0, ordy0, v1, ordy1, v2, ordy2} = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("reset_in_ready", 512'(rdy0), 512'(1));
        check("reset_out_valid", 512'(ov0), 512'(0));
        check("reset_busy", 512'(busy0), 512'(0));
        check("reset_mp", 512'(mp0), 512'(0));

        for (int v = 0; v < 4; v++) begin
            job0(vecs[v].a, vecs[v].b, vecs[v].mp, $sformatf("vec%0d", v));
        end

        // Consumer stall: result must hold while in_valid pulses are ignored.
        a0 = vecs[1].a;
        b0 = vecs[1].b;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        n  = 1;
        while (!ov0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int t = 0; t < 10; t++) begin
            v0 = t[0];
            a0 = {4{32'(t + 100)}};
            check($sformatf("stall%0d_out_valid", t), 512'(ov0), 512'(1));
            check($sformatf("stall%0d_in_ready", t), 512'(rdy0), 512'(0));
            check($sformatf("stall%0d_mp", t), 512'(mp0), 512'(vecs[1].mp));
            @(negedge clk);
        end
        v0    = 1'b0;
        ordy0 = 1'b1;
        @(negedge clk);
        ordy0 = 1'b0;
        check("stall_release_ready", 512'({rdy0, ov0, busy0}), 512'(3'b100));

        // Reset during the second MAC cycle.
        a0 = vecs[3].a;
        b0 = vecs[3].b;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_busy", 512'(busy0), 512'(0));
        check("midreset_out_valid", 512'(ov0), 512'(0));
        check("midreset_in_ready", 512'(rdy0), 512'(1));
        check("midreset_mp", 512'(mp0), 512'(0));
        job0(vecs[0].a, vecs[0].b, vecs[0].mp, "post_reset");

        // 8-bit wrap: 16*16 + 16*1 products and sums wrap modulo 256.
        a1 = {8'd16, 8'd16, 8'd1, 8'd1};
        b1 = {8'd16, 8'd16};
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        n  = 1;
        while (!ov1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("w8_latency", 512'(n), 512'(5));
        check("w8_mp", 512'(mp1), 512'(16'h0020));
        ordy1 = 1'b1;
        @(negedge clk);
        ordy1 = 1'b0;
        check("w8_ready_after", 512'(rdy1), 512'(1));

        // K=1 outer product.
        a2 = {32'd1, 32'd2, 32'd3};
        b2 = {32'd4, 32'd5, 32'd6};
        v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        n  = 1;
        while (!ov2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("k1_latency", 512'(n), 512'(10));
        check("k1_mp", 512'(mp2), 512'({32'd4, 32'd5, 32'd6, 32'd8, 32'd10, 32'd12,
                                        32'd12, 32'd15, 32'd18}));
        ordy2 = 1'b1;
        @(negedge clk);
        ordy2 = 1'b0;
        check("k1_ready_after", 512'(rdy2), 512'(1));

        // Back-to-back jobs with in_valid and out_ready held high.
        n_in   = 0;
        n_out  = 0;
        t_in   = '{0, 0};
        t_out  = '{0, 0};
        mp_out = '{64'd0, 64'd0};
        a0     = vecs[0].a;
        b0     = vecs[0].b;
        v0     = 1'b1;
        ordy0  = 1'b1;
        for (int c = 0; c < 40 && n_out < 2; c++) begin
            if (n_in == 1 && c == t_in[0] + 1) begin
                a0 = vecs[1].a;
                b0 = vecs[1].b;
            end
            if (v0 && rdy0 && n_in < 2) begin
                t_in[n_in] = c;
                n_in++;
            end
            if (ov0 && ordy0) begin
                t_out[n_out]  = c;
                mp_out[n_out] = mp0;
                n_out++;
            end
            @(negedge clk);
        end
        v0    = 1'b0;
        ordy0 = 1'b0;
        check("b2b_out_count", 512'(n_out), 512'(2));
        check("b2b_mp0", 512'(mp_out[0]), 512'(vecs[0].mp));
        check("b2b_mp1", 512'(mp_out[1]), 512'(vecs[1].mp));
        check("b2b_first_latency", 512'(t_out[0] - t_in[0]), 512'(5));
        check("b2b_second_accept", 512'(t_in[1] - t_out[0]), 512'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_mul_seq.md
Name: matrix_mul_seq

Overview:
- Sequential, resource-shared counterpart of the combinational matrix multiplier.
- Accepts flat-packed A (Amatrixrownum x Amatrixcolnum) and B (Amatrixcolnum x Bmatrixcolnum) through a valid/ready handshake.
- Computes MP = A*B with one multiplier and one accumulator, stepping row/column/inner indices under an FSM.
- Returns MP through a valid/ready handshake. Used where area matters more than latency.

Parameters:
word_size, 32, bit width of every matrix element
Amatrixrownum, 2, rows of A (= rows of MP)
Amatrixcolnum, 2, columns of A (= rows of B, inner dimension K), must be >= 1
Bmatrixcolnum, 1, columns of B (= columns of MP)

Ports:
clk  input  1  clock, all logic on its rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  A and B present and valid
in_ready  output  1  block can accept a new operand pair
A  input  Amatrixrownum*Amatrixcolnum*word_size  matrix A, flat packed
B  input  Amatrixcolnum*Bmatrixcolnum*word_size  matrix B, flat packed
out_valid  output  1  MP holds a complete result
out_ready  input  1  consumer accepts MP
MP  output  Amatrixrownum*Bmatrixcolnum*word_size  result matrix, flat packed
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n).
- Packing: element (r,c) of an R x C matrix has flat index n = r*C + c and occupies bits [R*C*word_size-1-n*word_size -: word_size]. Element (0,0) sits at the MSBs. The same rule applies to A, B and MP.
- Reset (rst_n=0 at a clock edge), taking priority over everything:
  - state=IDLE; in_ready=1; out_valid=0; busy=0; MP=0.
  - Operand registers, accumulator and counters i, j, k all cleared.
  - Reset mid-operation abandons the computation; no partial result is ever flagged valid.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid & in_ready: register A and B, clear i=j=k=0 and acc=0, go to COMPUTE.
    - Input changes after capture have no effect.
  - COMPUTE:
    - in_ready=0. Each cycle: acc_next = acc + A[i][k]*B[k][j].
    - If k < Amatrixcolnum-1: k++.
    - Else: write acc_next into MP element (i,j), clear acc and k, then advance j. When j wraps, clear j and increment i.
    - After writing element (Amatrixrownum-1, Bmatrixcolnum-1), go to DONE.
  - DONE:
    - out_valid=1; MP stable; in_ready=0.
    - On out_ready: out_valid drops next cycle, go to IDLE.
    - out_ready low holds DONE indefinitely.
- Arithmetic:
  - Product truncated to word_size LSBs; sum wraps modulo 2^word_size. Results are bit-identical to the combinational multiplier.
  - Unsigned arithmetic.
- Latency: let handshake cycle = c0.
  - MAC cycles run c0+1 .. c0+M*N*K, where M=Amatrixrownum, N=Bmatrixcolnum, K=Amatrixcolnum.
  - out_valid is first high in cycle c0+M*N*K+1.
  - Earliest next in_ready is the cycle after the out handshake.
  - Throughput is one job per M*N*K+2 cycles minimum.
- Boundaries:
  - K=1: the element is written every cycle and acc is never carried over.
  - in_valid while busy is ignored; it is neither queued nor dropped silently into state.
  - out_ready while not out_valid has no effect.
  - MP is updated element by element during COMPUTE. Consumers must only sample it while out_valid=1.
  - Counter widths are $clog2 of each dimension, minimum 1 bit.

Decomposition:
- Shared package matrix_pkg:
  - State encoding constants IDLE/COMPUTE/DONE.
  - Index-width helper function (clog2, min 1).
  - Flat-index-to-bit-offset function, shared with the combinational multiplier.
- One sub-module, matrix_mac: word_size multiply-add (acc + a*b, truncated). It is combinational and instanced once. The accumulator register stays in the parent.

Test Plan:
- 2x2*2x1, A={1,2,3,4}, B={5,6}, out_ready=1 → MP={17,39}; out_valid high exactly 5 cycles after handshake; in_ready high the cycle after the out handshake.
- word_size=8, A={16,16,1,1}, B={16,16} → MP={0x00,0x20}; product and sum wrap with no overflow flag.
- out_ready held low 10 cycles after out_valid → MP and out_valid stable throughout; in_valid pulses in that window are ignored (in_ready=0).
- rst_n=0 for one cycle at the 2nd MAC cycle → next cycle state IDLE, out_valid=0, MP=0; a fresh job afterward gives the correct result.
- Amatrixrownum=3, Amatrixcolnum=1, Bmatrixcolnum=3, A={1,2,3}, B={4,5,6} → MP={4,5,6,8,10,12,12,15,18}; out_valid at cycle c0+10.
- Back-to-back jobs with in_valid held high and out_ready=1 → both results correct; second handshake no earlier than one cycle after the first out handshake.
